// File: rtl/sdram_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_responder_if
//  Description : SDRAM command/data bus between a controller (master) and
//                the device-side responder (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface sdram_responder_if #(
    parameter int BANK_BITS = 2
);
    logic                 sd_cke;
    logic                 sd_cs_n;
    logic                 sd_ras_n;
    logic                 sd_cas_n;
    logic                 sd_we_n;
    logic [BANK_BITS-1:0] sd_ba;
    logic [12:0]          sd_addr;
    logic [1:0]           sd_dqm;
    logic                 dq_oe_in;
    logic [15:0]          dq_in;
    logic                 rd_oe;
    logic [15:0]          dq_rd;

    modport master (
        output sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n,
        output sd_ba, sd_addr, sd_dqm, dq_oe_in, dq_in,
        input  rd_oe, dq_rd
    );

    modport slave (
        input  sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n,
        input  sd_ba, sd_addr, sd_dqm, dq_oe_in, dq_in,
        output rd_oe, dq_rd
    );
endinterface
`default_nettype wire

// File: rtl/sdram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_responder
//  Description : Device-side SDRAM model for loopback harnesses. Decodes
//                ACTIVE/READ/WRITE/PRECHARGE/REFRESH/MRS, tracks per-bank
//                open rows, stores data in a small backing memory and returns
//                read data after the programmed CAS latency.
//                Define SDRAM_RESP_CHECK_EN to compile in the timing counters
//                and the sticky protocol-error flags; otherwise err is 0 and
//                commands execute regardless of timing or bank state.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_responder #(
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 9,
    parameter int BANK_BITS = 2,
    parameter int MEM_AW    = 10,
    parameter int CL_RESET  = 3,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_RFC     = 7,
    parameter int T_WR      = 3
) (
    input  logic             clk,
    input  logic             rst,
    sdram_responder_if.slave bus,
    output logic             mrs_done,
    output logic [5:0]       err
);

    localparam int NB     = 1 << BANK_BITS;
    localparam int FULL_W = BANK_BITS + ROW_BITS + COL_BITS;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_NOP = 3'b111
    } cmd_e;

    // One entry of the read-latency pipe.
    typedef struct packed {
        logic              valid;
        logic [MEM_AW-1:0] idx;
        logic [1:0]        dqm;
    } rd_ent_t;

    cmd_e                cmd;
    logic [FULL_W-1:0]   full_addr;
    logic [MEM_AW-1:0]   cmd_idx;
    logic                mrs_ok;
    logic                bank_ok;
    logic                wr_lo;
    logic                wr_hi;
    rd_ent_t             new_ent;

    logic [2:0]          cl_q, cl_d;
    logic                mrs_done_q, mrs_done_d;
    logic [ROW_BITS-1:0] row_q [NB];
    logic [ROW_BITS-1:0] row_d [NB];
    rd_ent_t             pipe0_q, pipe0_d;
    rd_ent_t             pipe1_q, pipe1_d;
    logic                rd_oe_q, rd_oe_d;
    logic [15:0]         dq_rd_q, dq_rd_d;

    logic [15:0]         mem [2**MEM_AW];

    // Command decode: deselect or clock-disabled cycles are NOPs.
    always_comb begin
        cmd = CMD_NOP;
        if (bus.sd_cke && !bus.sd_cs_n) begin
            case ({bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_RD;
                3'b100:  cmd = CMD_WR;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    // Word index: low MEM_AW bits of {bank, open row, column}.
    assign full_addr = {bus.sd_ba, row_q[bus.sd_ba], bus.sd_addr[COL_BITS-1:0]};
    assign cmd_idx   = full_addr[MEM_AW-1:0];
    assign mrs_ok    = (bus.sd_addr[6:4] == 3'd2) || (bus.sd_addr[6:4] == 3'd3);

    assign new_ent.valid = 1'b1;
    assign new_ent.idx   = cmd_idx;
    assign new_ent.dqm   = bus.sd_dqm;

`ifdef SDRAM_RESP_CHECK_EN
    localparam int T_MAX_A = (T_RCD > T_RP)    ? T_RCD   : T_RP;
    localparam int T_MAX_B = (T_RFC > T_WR)    ? T_RFC   : T_WR;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W   = $clog2(T_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t RCD_LD  = cnt_t'(T_RCD - 1);
    localparam cnt_t RP_LD   = cnt_t'(T_RP - 1);
    localparam cnt_t RFC_LD  = cnt_t'(T_RFC - 1);
    localparam cnt_t WR_LD   = cnt_t'(T_WR);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    logic       open_q  [NB];
    logic       open_d  [NB];
    cnt_t       rcd_q   [NB];
    cnt_t       rcd_d   [NB];
    cnt_t       rp_q    [NB];
    cnt_t       rp_d    [NB];
    cnt_t       wr_q    [NB];
    cnt_t       wr_d    [NB];
    logic       wr_ap_q [NB];
    logic       wr_ap_d [NB];
    cnt_t       rfc_q, rfc_d;
    logic [5:0] err_q, err_d;
    logic       any_open;
    logic       ap;

    assign ap = bus.sd_addr[10];

    function automatic cnt_t dec_sat(input cnt_t v);
        return (v == '0) ? v : v - CNT_ONE;
    endfunction

    // Bank state: counters count down, pending write auto-precharges mature,
    // then the current command updates the addressed bank(s).
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            open_d[b]  = open_q[b];
            rcd_d[b]   = dec_sat(rcd_q[b]);
            rp_d[b]    = dec_sat(rp_q[b]);
            wr_d[b]    = wr_q[b];
            wr_ap_d[b] = wr_ap_q[b];
            if (wr_ap_q[b]) begin
                if (wr_q[b] <= CNT_ONE) begin
                    wr_ap_d[b] = 1'b0;
                    wr_d[b]    = '0;
                    open_d[b]  = 1'b0;
                    rp_d[b]    = RP_LD;
                end else begin
                    wr_d[b] = wr_q[b] - CNT_ONE;
                end
            end
        end
        rfc_d = dec_sat(rfc_q);
        case (cmd)
            CMD_ACT: begin
                open_d[bus.sd_ba] = 1'b1;
                rcd_d[bus.sd_ba]  = RCD_LD;
            end
            CMD_RD: begin
                if (ap) begin
                    open_d[bus.sd_ba]  = 1'b0;
                    rp_d[bus.sd_ba]    = RP_LD;
                    wr_ap_d[bus.sd_ba] = 1'b0;
                end
            end
            CMD_WR: begin
                if (ap && open_q[bus.sd_ba]) begin
                    wr_ap_d[bus.sd_ba] = 1'b1;
                    wr_d[bus.sd_ba]    = WR_LD;
                end
            end
            CMD_PRE: begin
                for (int b = 0; b < NB; b++) begin
                    if (ap || (BANK_BITS'(b) == bus.sd_ba)) begin
                        open_d[b]  = 1'b0;
                        rp_d[b]    = RP_LD;
                        wr_ap_d[b] = 1'b0;
                        wr_d[b]    = '0;
                    end
                end
            end
            CMD_REF: rfc_d = RFC_LD;
            default: ;
        endcase
    end

    // Sticky protocol-error flags, judged against pre-edge state.
    always_comb begin
        any_open = 1'b0;
        for (int b = 0; b < NB; b++) begin
            any_open = any_open | open_q[b];
        end
        err_d    = err_q;
        err_d[0] = err_q[0] | ((cmd == CMD_ACT) &&
                   (open_q[bus.sd_ba] || (rp_q[bus.sd_ba] != '0)));
        err_d[1] = err_q[1] | (((cmd == CMD_RD) || (cmd == CMD_WR)) &&
                   (!open_q[bus.sd_ba] || (rcd_q[bus.sd_ba] != '0)));
        err_d[2] = err_q[2] | ((cmd == CMD_REF) && any_open) |
                   ((cmd != CMD_NOP) && (rfc_q != '0));
        err_d[3] = err_q[3] | (((cmd == CMD_ACT) || (cmd == CMD_RD) ||
                   (cmd == CMD_WR)) && !mrs_done_q);
        err_d[4] = err_q[4] | ((cmd == CMD_MRS) && !mrs_ok);
        err_d[5] = err_q[5] | ((cmd == CMD_WR) && !bus.dq_oe_in);
    end

    // Checker state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                open_q[b]  <= 1'b0;
                rcd_q[b]   <= '0;
                rp_q[b]    <= '0;
                wr_q[b]    <= '0;
                wr_ap_q[b] <= 1'b0;
            end
            rfc_q <= '0;
            err_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                open_q[b]  <= open_d[b];
                rcd_q[b]   <= rcd_d[b];
                rp_q[b]    <= rp_d[b];
                wr_q[b]    <= wr_d[b];
                wr_ap_q[b] <= wr_ap_d[b];
            end
            rfc_q <= rfc_d;
            err_q <= err_d;
        end
    end

    // A closed bank has no valid row, so no access is made.
    assign bank_ok = open_q[bus.sd_ba];
    assign err     = err_q;

    logic unused_sigs;
    assign unused_sigs = &{1'b0, full_addr[FULL_W-1:MEM_AW]};
`else
    // Without checking, accesses always go ahead using the last latched row.
    assign bank_ok = 1'b1;
    assign err     = '0;

    logic unused_sigs;
    assign unused_sigs = &{1'b0, bus.dq_oe_in, full_addr[FULL_W-1:MEM_AW]};
`endif

    // Mode register and per-bank row latch.
    always_comb begin
        cl_d       = cl_q;
        mrs_done_d = mrs_done_q;
        for (int b = 0; b < NB; b++) begin
            row_d[b] = row_q[b];
        end
        if ((cmd == CMD_MRS) && mrs_ok) begin
            cl_d       = bus.sd_addr[6:4];
            mrs_done_d = 1'b1;
        end
        if (cmd == CMD_ACT) begin
            row_d[bus.sd_ba] = bus.sd_addr[ROW_BITS-1:0];
        end
    end

    // Read latency pipe: CL3 reads enter one stage earlier than CL2 reads;
    // data is fetched from memory only when the entry reaches the output.
    always_comb begin
        pipe0_d = '0;
        pipe1_d = pipe0_q;
        if ((cmd == CMD_RD) && bank_ok) begin
            if (cl_q == 3'd3) begin
                pipe0_d = new_ent;
            end else begin
                pipe1_d = new_ent;
            end
        end
        rd_oe_d = pipe1_q.valid;
        dq_rd_d = '0;
        if (pipe1_q.valid) begin
            dq_rd_d[7:0]  = pipe1_q.dqm[0] ? 8'h00 : mem[pipe1_q.idx][7:0];
            dq_rd_d[15:8] = pipe1_q.dqm[1] ? 8'h00 : mem[pipe1_q.idx][15:8];
        end
    end

    // Control and read-path registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cl_q       <= 3'(CL_RESET);
            mrs_done_q <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                row_q[b] <= '0;
            end
            pipe0_q    <= '0;
            pipe1_q    <= '0;
            rd_oe_q    <= 1'b0;
            dq_rd_q    <= '0;
        end else begin
            cl_q       <= cl_d;
            mrs_done_q <= mrs_done_d;
            for (int b = 0; b < NB; b++) begin
                row_q[b] <= row_d[b];
            end
            pipe0_q    <= pipe0_d;
            pipe1_q    <= pipe1_d;
            rd_oe_q    <= rd_oe_d;
            dq_rd_q    <= dq_rd_d;
        end
    end

    assign wr_lo = !rst && (cmd == CMD_WR) && bank_ok && !bus.sd_dqm[0];
    assign wr_hi = !rst && (cmd == CMD_WR) && bank_ok && !bus.sd_dqm[1];

    // Backing store, byte-masked writes; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_lo) begin
            mem[cmd_idx][7:0] <= bus.dq_in[7:0];
        end
        if (wr_hi) begin
            mem[cmd_idx][15:8] <= bus.dq_in[15:8];
        end
    end

    assign bus.rd_oe = rd_oe_q;
    assign bus.dq_rd = dq_rd_q;
    assign mrs_done  = mrs_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_responder
//  Description : Directed self-checking bench for sdram_responder. Error-flag
//                expectations follow whether SDRAM_RESP_CHECK_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_responder;

`ifdef SDRAM_RESP_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_MRS = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic       mrs_done;
    logic [5:0] err;
    int         n_assert = 0;
    int         n_fail   = 0;

    sdram_responder_if #(.BANK_BITS(2)) bus ();

    sdram_responder dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mrs_done (mrs_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_err(input logic [5:0] e);
        return CHECK ? {10'b0, e} : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one command for exactly one rising edge, then return to deselect.
    task automatic issue(input logic [2:0] rcw, input logic [1:0] ba,
                         input logic [12:0] addr, input logic [1:0] dqm,
                         input logic oe, input logic [15:0] data);
        bus.sd_cs_n = 1'b0;
        {bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n} = rcw;
        bus.sd_ba    = ba;
        bus.sd_addr  = addr;
        bus.sd_dqm   = dqm;
        bus.dq_oe_in = oe;
        bus.dq_in    = data;
        @(posedge clk);
        #1;
        bus.sd_cs_n = 1'b1;
        {bus.sd_ras_n, bus.sd_cas_n, bus.sd_we_n} = 3'b111;
        bus.sd_ba    = '0;
        bus.sd_addr  = '0;
        bus.sd_dqm   = '0;
        bus.dq_oe_in = 1'b0;
        bus.dq_in    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.sd_cke   = 1'b1;
        bus.sd_cs_n  = 1'b1;
        bus.sd_ras_n = 1'b1;
        bus.sd_cas_n = 1'b1;
        bus.sd_we_n  = 1'b1;
        bus.sd_ba    = '0;
        bus.sd_addr  = '0;
        bus.sd_dqm   = '0;
        bus.dq_oe_in = 1'b0;
        bus.dq_in    = '0;
        idle(2);
        check("rst_rd_oe",    {15'b0, bus.rd_oe}, 16'h0000);
        check("rst_dq_rd",    bus.dq_rd,          16'h0000);
        check("rst_mrs_done", {15'b0, mrs_done},  16'h0000);
        check("rst_err",      {10'b0, err},       16'h0000);
        rst = 1'b0;

        // Init: precharge all, two refreshes 7 apart, MRS CL=3
        issue(C_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        idle(6);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        idle(6);
        issue(C_MRS, 2'd0, 13'h030, 2'b00, 1'b0, 16'h0);
        check("init_mrs_done", {15'b0, mrs_done}, 16'h0001);
        check("init_err",      {10'b0, err},      16'h0000);

        // Write with auto-precharge, reopen, read at CL=3
        issue(C_ACT, 2'd1, 13'h123, 2'b00, 1'b0, 16'h0);
        idle(2);
        issue(C_WR,  2'd1, 13'h405, 2'b00, 1'b1, 16'hBEEF);
        idle(5);
        issue(C_ACT, 2'd1, 13'h123, 2'b00, 1'b0, 16'h0);
        idle(2);
        issue(C_RD,  2'd1, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        check("cl3_early_oe", {15'b0, bus.rd_oe}, 16'h0000);
        idle(1);
        check("cl3_oe",       {15'b0, bus.rd_oe}, 16'h0001);
        check("cl3_data",     bus.dq_rd,          16'hBEEF);
        idle(1);
        check("cl3_oe_drop",  {15'b0, bus.rd_oe}, 16'h0000);
        check("cl3_err",      {10'b0, err},       16'h0000);

        // CL=2 read
        issue(C_MRS, 2'd0, 13'h020, 2'b00, 1'b0, 16'h0);
        issue(C_RD,  2'd1, 13'h005, 2'b00, 1'b0, 16'h0);
        check("cl2_early_oe", {15'b0, bus.rd_oe}, 16'h0000);
        idle(1);
        check("cl2_oe",       {15'b0, bus.rd_oe}, 16'h0001);
        check("cl2_data",     bus.dq_rd,          16'hBEEF);
        idle(1);
        check("cl2_oe_drop",  {15'b0, bus.rd_oe}, 16'h0000);

        // Bad MRS keeps CL=2
        issue(C_MRS, 2'd0, 13'h050, 2'b00, 1'b0, 16'h0);
        check("bad_mrs_err",  {10'b0, err}, exp_err(6'h10));
        issue(C_RD,  2'd1, 13'h005, 2'b00, 1'b0, 16'h0);
        idle(1);
        check("bad_mrs_oe",   {15'b0, bus.rd_oe}, 16'h0001);
        check("bad_mrs_data", bus.dq_rd,          16'hBEEF);

        // READ too soon after ACTIVE, fully masked; then ACTIVE to open bank
        issue(C_ACT, 2'd2, 13'h000, 2'b00, 1'b0, 16'h0);
        issue(C_RD,  2'd2, 13'h000, 2'b11, 1'b0, 16'h0);
        check("rcd_err",      {10'b0, err}, exp_err(6'h12));
        idle(1);
        check("mask_all_oe",  {15'b0, bus.rd_oe}, 16'h0001);
        check("mask_all_dat", bus.dq_rd,          16'h0000);
        issue(C_ACT, 2'd1, 13'h123, 2'b00, 1'b0, 16'h0);
        check("act_open_err", {10'b0, err}, exp_err(6'h13));
        idle(2);

        // Byte-masked write, then back-to-back reads with and without mask
        issue(C_WR,  2'd1, 13'h005, 2'b10, 1'b1, 16'h1234);
        issue(C_RD,  2'd1, 13'h005, 2'b00, 1'b0, 16'h0);
        issue(C_RD,  2'd1, 13'h005, 2'b01, 1'b0, 16'h0);
        check("wmask_oe",     {15'b0, bus.rd_oe}, 16'h0001);
        check("wmask_data",   bus.dq_rd,          16'hBE34);
        idle(1);
        check("rmask_oe",     {15'b0, bus.rd_oe}, 16'h0001);
        check("rmask_data",   bus.dq_rd,          16'hBE00);
        idle(1);
        check("b2b_oe_drop",  {15'b0, bus.rd_oe}, 16'h0000);
        check("b2b_err",      {10'b0, err}, exp_err(6'h13));

        // Command during refresh busy time
        issue(C_PRE, 2'd0, 13'h400, 2'b00, 1'b0, 16'h0);
        idle(2);
        issue(C_REF, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        idle(2);
        issue(C_ACT, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        check("rfc_err",      {10'b0, err}, exp_err(6'h17));
        idle(4);

        // Reset with a CL=3 read in flight
        issue(C_MRS, 2'd0, 13'h030, 2'b00, 1'b0, 16'h0);
        issue(C_RD,  2'd0, 13'h000, 2'b11, 1'b0, 16'h0);
        rst = 1'b1;
        idle(1);
        check("flush_oe",       {15'b0, bus.rd_oe}, 16'h0000);
        check("flush_err",      {10'b0, err},       16'h0000);
        check("flush_mrs_done", {15'b0, mrs_done},  16'h0000);
        rst = 1'b0;
        idle(1);
        check("flush_oe_late",  {15'b0, bus.rd_oe}, 16'h0000);

        // ACTIVE before any MRS
        issue(C_ACT, 2'd0, 13'h000, 2'b00, 1'b0, 16'h0);
        check("no_mrs_err",   {10'b0, err}, exp_err(6'h08));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
